// File: rtl/output_link_tx_if.sv
// Flit bus between crossbar, TX block and link; slave is the TX block's view.
// flit_in moves on a cycle where flit_in_valid & flit_in_ready; flit_o_valid is a one-cycle push strobe.
interface output_link_tx_if;
    logic [63:0] flit_in;
    logic        flit_in_valid;
    logic        flit_in_ready;
    logic [63:0] flit_o;
    logic        flit_o_valid;
    logic        buffer_on;

    modport master (
        output flit_in, flit_in_valid, buffer_on,
        input  flit_in_ready, flit_o, flit_o_valid
    );

    modport slave (
        input  flit_in, flit_in_valid, buffer_on,
        output flit_in_ready, flit_o, flit_o_valid
    );
endinterface

// File: rtl/output_link_tx.sv
// Router output port transmitter: TX FIFO, wormhole framing check and
// on/off-gated launch onto the link.
module output_link_tx #(
    parameter int TX_DEPTH     = 4,
    parameter int ON_OFF_DELAY = 2,
    parameter int CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    output_link_tx_if.slave      lnk,
    output logic                 pkt_active,
    output logic                 proto_err,
    output logic [CNT_W-1:0]     flit_cnt,
    output logic                 tx_empty,
    output logic                 dbg_state
);

    localparam int AW = $clog2(TX_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(TX_DEPTH);

    if (TX_DEPTH < 2 || (TX_DEPTH & (TX_DEPTH - 1)) != 0 || ON_OFF_DELAY < 1) begin : g_cfg_check
        $error("output_link_tx: TX_DEPTH must be a power of 2 >= 2, ON_OFF_DELAY >= 1");
    end

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PKT  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [63:0]       mem_q [TX_DEPTH];
    logic [63:0]       mem_d [TX_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [63:0]       flit_o_q, flit_o_d;
    logic              flit_o_valid_q, flit_o_valid_d;
    logic              on_q, on_d;
    logic              proto_err_q, proto_err_d;
    logic              pkt_active_q, pkt_active_d;
    logic [CNT_W-1:0]  flit_cnt_q, flit_cnt_d;

    logic full, empty, accept, push, pop, is_head, is_tail;

    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign accept  = lnk.flit_in_valid & ~full;
    // Type encoding: bit 62 marks a head, bit 63 marks a tail (11 = single-flit packet).
    assign is_head = lnk.flit_in[62];
    assign is_tail = lnk.flit_in[63];
    assign pop     = ~empty & on_q;

    always_comb begin
        state_d     = state_q;
        proto_err_d = proto_err_q;
        push        = 1'b0;
        if (accept) begin
            case (state_q)
                S_IDLE: begin
                    if (is_head) begin
                        push = 1'b1;
                        if (!is_tail) state_d = S_PKT;
                    end else begin
                        proto_err_d = 1'b1;
                    end
                end
                default: begin
                    if (!is_head) begin
                        push = 1'b1;
                        if (is_tail) state_d = S_IDLE;
                    end else begin
                        proto_err_d = 1'b1;
                    end
                end
            endcase
        end
        pkt_active_d = (state_d == S_PKT);
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = lnk.flit_in;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end

        rd_ptr_d       = rd_ptr_q;
        flit_o_d       = flit_o_q;
        flit_o_valid_d = 1'b0;
        flit_cnt_d     = flit_cnt_q;
        if (pop) begin
            flit_o_d       = mem_q[rd_ptr_q];
            flit_o_valid_d = 1'b1;
            rd_ptr_d       = rd_ptr_q + AW'(1);
            flit_cnt_d     = flit_cnt_q + CNT_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Registered once so buffer_on never reaches flit_o_valid combinationally.
        on_d = lnk.buffer_on;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            for (int i = 0; i < TX_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            flit_o_q       <= '0;
            flit_o_valid_q <= 1'b0;
            on_q           <= 1'b1;
            proto_err_q    <= 1'b0;
            pkt_active_q   <= 1'b0;
            flit_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            mem_q          <= mem_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            flit_o_q       <= flit_o_d;
            flit_o_valid_q <= flit_o_valid_d;
            on_q           <= on_d;
            proto_err_q    <= proto_err_d;
            pkt_active_q   <= pkt_active_d;
            flit_cnt_q     <= flit_cnt_d;
        end
    end

    assign lnk.flit_in_ready = ~full;
    assign lnk.flit_o        = flit_o_q;
    assign lnk.flit_o_valid  = flit_o_valid_q;
    assign pkt_active        = pkt_active_q;
    assign proto_err         = proto_err_q;
    assign flit_cnt          = flit_cnt_q;
    assign tx_empty          = empty;
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_output_link_tx.sv
// Bench for output_link_tx: random flits against a packet-level framing model
// and an in-order expected queue of flits that must appear on the link.
module tb_output_link_tx;

    localparam int CNT_W        = 16;
    localparam int TX_DEPTH     = 4;
    localparam int ON_OFF_DELAY = 2;
    localparam logic [1:0] T_BODY = 2'b00;
    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b10;
    localparam logic [1:0] T_HT   = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    output_link_tx_if bus();
    logic             pkt_active, proto_err, tx_empty, dbg_state;
    logic [CNT_W-1:0] flit_cnt;

    output_link_tx #(.TX_DEPTH(TX_DEPTH), .ON_OFF_DELAY(ON_OFF_DELAY), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .lnk        (bus),
        .pkt_active (pkt_active),
        .proto_err  (proto_err),
        .flit_cnt   (flit_cnt),
        .tx_empty   (tx_empty),
        .dbg_state  (dbg_state)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [63:0]      exp_q[$];
    logic [63:0]      got_q[$];
    int               got_cyc[$];
    int               cyc      = 0;
    int               n_launch = 0;
    bit               rec_en   = 1'b1;
    bit               m_open   = 1'b0;
    bit               m_err    = 1'b0;
    logic [CNT_W-1:0] exp_cnt  = '0;

    // Link monitor: records every launched flit just after the edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (rst && bus.flit_o_valid) begin
            n_launch++;
            if (rec_en) begin
                got_q.push_back(bus.flit_o);
                got_cyc.push_back(cyc);
            end
        end
    end

    function automatic logic [63:0] mk(input logic [1:0] t);
        logic [63:0] f;
        f = {$urandom, $urandom};
        f[63:62] = t;
        return f;
    endfunction

    // Offer one flit from a negedge; returns at the negedge after acceptance with valid still high.
    task automatic send(input logic [63:0] f);
        int guard = 0;
        bit ok;
        bus.flit_in       = f;
        bus.flit_in_valid = 1'b1;
        while (!bus.flit_in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            n_chk++;
            $display("FAIL send_timeout: flit_in_ready low for %0d cycles, required high", guard);
            bus.flit_in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (!m_open) ok = (f[63:62] == T_HEAD) || (f[63:62] == T_HT);
        else         ok = (f[63:62] == T_BODY) || (f[63:62] == T_TAIL);
        if (ok) begin
            exp_q.push_back(f);
            exp_cnt++;
            if (f[63:62] == T_HEAD) m_open = 1'b1;
            if (f[63:62] == T_TAIL) m_open = 1'b0;
        end else begin
            m_err = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        bus.flit_in_valid = 1'b0;
    endtask

    task automatic wait_drain(output bit ok);
        int guard = 0;
        while (!tx_empty && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        ok = tx_empty;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.buffer_on = 1'b1;
        bus.flit_in_valid = 1'b0;
        bus.flit_in = '0;
        repeat (3) @(negedge clk);
        n_chk++; if (bus.flit_o !== 64'h0) $display("FAIL rst_flit_o: got %h required 0", bus.flit_o); else n_pass++;
        n_chk++; if (bus.flit_o_valid !== 1'b0) $display("FAIL rst_valid: got %b required 0", bus.flit_o_valid); else n_pass++;
        n_chk++; if (bus.flit_in_ready !== 1'b1) $display("FAIL rst_ready: got %b required 1", bus.flit_in_ready); else n_pass++;
        n_chk++; if (pkt_active !== 1'b0) $display("FAIL rst_pkt_active: got %b required 0", pkt_active); else n_pass++;
        n_chk++; if (proto_err !== 1'b0) $display("FAIL rst_proto_err: got %b required 0", proto_err); else n_pass++;
        n_chk++; if (flit_cnt !== '0) $display("FAIL rst_flit_cnt: got %0d required 0", flit_cnt); else n_pass++;
        n_chk++; if (tx_empty !== 1'b1) $display("FAIL rst_tx_empty: got %b required 1", tx_empty); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_stream();
        bit ok;
        bus.buffer_on = 1'b1;
        @(negedge clk);
        send(mk(T_HEAD));
        n_chk++; if (pkt_active !== 1'b1) $display("FAIL stream_pkt_head: got %b required 1", pkt_active); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            send(mk(T_BODY));
            n_chk++; if (pkt_active !== 1'b1) $display("FAIL stream_pkt_body%0d: got %b required 1", i, pkt_active); else n_pass++;
        end
        send(mk(T_TAIL));
        idle();
        n_chk++; if (pkt_active !== 1'b0) $display("FAIL stream_pkt_tail: got %b required 0", pkt_active); else n_pass++;
        wait_drain(ok);
        n_chk++; if (!ok) $display("FAIL stream_drain: tx_empty %b required 1", tx_empty); else n_pass++;
        n_chk++;
        if (got_cyc.size() != 8 || got_cyc[got_cyc.size()-1] - got_cyc[0] != 7)
            $display("FAIL stream_b2b: got %0d launches, required 8 in consecutive cycles", got_cyc.size());
        else n_pass++;
        n_chk++; if (got_q.size() != exp_q.size()) $display("FAIL stream_len: got %0d required %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_chk++; if (got_q[i] !== exp_q[i]) $display("FAIL stream_data[%0d]: got %h required %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
        n_chk++; if (flit_cnt !== exp_cnt) $display("FAIL stream_cnt: got %0d required %0d", flit_cnt, exp_cnt); else n_pass++;
        got_q.delete(); got_cyc.delete(); exp_q.delete();
    endtask

    task automatic test_mid_reset();
        logic [63:0] f;
        bit ok;
        bus.buffer_on = 1'b0;
        repeat (2) @(negedge clk);
        send(mk(T_HEAD));
        send(mk(T_BODY));
        send(mk(T_BODY));
        idle();
        n_chk++; if (pkt_active !== 1'b1 || tx_empty !== 1'b0) $display("FAIL midrst_pre: pkt_active %b tx_empty %b required 1 0", pkt_active, tx_empty); else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_chk++; if (bus.flit_in_ready !== 1'b1) $display("FAIL midrst_ready: got %b required 1", bus.flit_in_ready); else n_pass++;
        n_chk++; if (tx_empty !== 1'b1) $display("FAIL midrst_empty: got %b required 1", tx_empty); else n_pass++;
        n_chk++; if (pkt_active !== 1'b0) $display("FAIL midrst_pkt: got %b required 0", pkt_active); else n_pass++;
        n_chk++; if (bus.flit_o !== 64'h0 || bus.flit_o_valid !== 1'b0) $display("FAIL midrst_flit_o: got %h/%b required 0/0", bus.flit_o, bus.flit_o_valid); else n_pass++;
        n_chk++; if (flit_cnt !== '0) $display("FAIL midrst_cnt: got %0d required 0", flit_cnt); else n_pass++;
        exp_q.delete(); got_q.delete(); got_cyc.delete();
        m_open = 1'b0; m_err = 1'b0; exp_cnt = '0;
        bus.buffer_on = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        f = mk(T_HT);
        send(f);
        idle();
        n_chk++; if (bus.flit_o_valid !== 1'b0) $display("FAIL latency_early: valid %b one edge after accept, required 0", bus.flit_o_valid); else n_pass++;
        @(negedge clk);
        n_chk++; if (bus.flit_o_valid !== 1'b1 || bus.flit_o !== f) $display("FAIL latency: got %h/%b required %h/1", bus.flit_o, bus.flit_o_valid, f); else n_pass++;
        wait_drain(ok);
        n_chk++; if (flit_cnt !== exp_cnt) $display("FAIL latency_cnt: got %0d required %0d", flit_cnt, exp_cnt); else n_pass++;
        got_q.delete(); got_cyc.delete(); exp_q.delete();
    endtask

    task automatic test_stop();
        int at_drop, n1, guard;
        bit ok;
        bus.buffer_on = 1'b1;
        @(negedge clk);
        send(mk(T_HEAD));
        send(mk(T_BODY));
        send(mk(T_BODY));
        bus.buffer_on = 1'b0;
        at_drop = n_launch;
        send(mk(T_BODY));
        send(mk(T_BODY));
        idle();
        repeat (4) @(negedge clk);
        n_chk++; if (n_launch - at_drop > ON_OFF_DELAY) $display("FAIL stop_bound: got %0d launches after off, required <= %0d", n_launch - at_drop, ON_OFF_DELAY); else n_pass++;
        n1 = n_launch;
        repeat (3) @(negedge clk);
        n_chk++; if (n_launch != n1) $display("FAIL stop_quiet: got %0d launches while off, required 0", n_launch - n1); else n_pass++;
        guard = 0;
        while (bus.flit_in_ready && guard < 8) begin
            send(mk(T_BODY));
            guard++;
        end
        idle();
        n_chk++; if (bus.flit_in_ready !== 1'b0) $display("FAIL stop_full_ready: got %b required 0", bus.flit_in_ready); else n_pass++;
        n_chk++; if (exp_q.size() - got_q.size() != TX_DEPTH) $display("FAIL stop_fill: got %0d queued required %0d", exp_q.size() - got_q.size(), TX_DEPTH); else n_pass++;
        n_chk++; if (tx_empty !== 1'b0) $display("FAIL stop_empty: got %b required 0", tx_empty); else n_pass++;
        bus.buffer_on = 1'b1;
        send(mk(T_TAIL));
        idle();
        wait_drain(ok);
        n_chk++; if (!ok) $display("FAIL stop_drain: tx_empty %b required 1", tx_empty); else n_pass++;
        n_chk++; if (got_q.size() != exp_q.size()) $display("FAIL stop_len: got %0d required %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_chk++; if (got_q[i] !== exp_q[i]) $display("FAIL stop_data[%0d]: got %h required %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
        n_chk++; if (flit_cnt !== exp_cnt) $display("FAIL stop_cnt: got %0d required %0d", flit_cnt, exp_cnt); else n_pass++;
        got_q.delete(); got_cyc.delete(); exp_q.delete();
    endtask

    task automatic test_framing();
        bit ok;
        bus.buffer_on = 1'b1;
        n_chk++; if (proto_err !== 1'b0) $display("FAIL frame_clean: got %b required 0", proto_err); else n_pass++;
        send(mk(T_BODY));
        n_chk++; if (proto_err !== m_err || pkt_active !== m_open) $display("FAIL frame_body_idle: err/pkt %b/%b required %b/%b", proto_err, pkt_active, m_err, m_open); else n_pass++;
        send(mk(T_HEAD));
        send(mk(T_HEAD));
        send(mk(T_HT));
        n_chk++; if (proto_err !== m_err || pkt_active !== m_open) $display("FAIL frame_head_pkt: err/pkt %b/%b required %b/%b", proto_err, pkt_active, m_err, m_open); else n_pass++;
        send(mk(T_BODY));
        send(mk(T_TAIL));
        send(mk(T_TAIL));
        idle();
        n_chk++; if (pkt_active !== m_open) $display("FAIL frame_close: got %b required %b", pkt_active, m_open); else n_pass++;
        wait_drain(ok);
        n_chk++; if (got_q.size() != exp_q.size()) $display("FAIL frame_len: got %0d required %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_chk++; if (got_q[i] !== exp_q[i]) $display("FAIL frame_data[%0d]: got %h required %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
        n_chk++; if (proto_err !== 1'b1) $display("FAIL frame_sticky: got %b required 1", proto_err); else n_pass++;
        got_q.delete(); got_cyc.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        bit ok;
        for (int i = 0; i < 80; i++) begin
            bus.buffer_on = ($urandom_range(0, 3) != 0);
            if (!bus.flit_in_ready) bus.buffer_on = 1'b1;
            send(mk(2'($urandom_range(0, 3))));
            if ($urandom_range(0, 3) == 0) begin
                idle();
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        bus.buffer_on = 1'b1;
        if (m_open) send(mk(T_TAIL));
        idle();
        wait_drain(ok);
        n_chk++; if (!ok) $display("FAIL rand_drain: tx_empty %b required 1", tx_empty); else n_pass++;
        n_chk++; if (got_q.size() != exp_q.size()) $display("FAIL rand_len: got %0d required %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_chk++; if (got_q[i] !== exp_q[i]) $display("FAIL rand_data[%0d]: got %h required %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
        n_chk++; if (proto_err !== m_err || pkt_active !== m_open) $display("FAIL rand_state: err/pkt %b/%b required %b/%b", proto_err, pkt_active, m_err, m_open); else n_pass++;
        n_chk++; if (flit_cnt !== exp_cnt) $display("FAIL rand_cnt: got %0d required %0d", flit_cnt, exp_cnt); else n_pass++;
        got_q.delete(); got_cyc.delete(); exp_q.delete();
    endtask

    task automatic test_simul();
        int n1;
        bit steady = 1'b1;
        bit ok;
        bus.buffer_on = 1'b0;
        repeat (2) @(negedge clk);
        n1 = n_launch;
        for (int i = 0; i < 3; i++) send(mk(T_HT));
        idle();
        n_chk++; if (exp_q.size() - got_q.size() != 3 || bus.flit_in_ready !== 1'b1 || n_launch != n1)
            $display("FAIL simul_pre: queued %0d ready %b launches %0d, required 3 1 0", exp_q.size() - got_q.size(), bus.flit_in_ready, n_launch - n1);
        else n_pass++;
        bus.buffer_on = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            send(mk(T_HT));
            if (exp_q.size() - got_q.size() != 3 || bus.flit_in_ready !== 1'b1 || tx_empty !== 1'b0) steady = 1'b0;
        end
        idle();
        n_chk++; if (!steady) $display("FAIL simul_steady: occupancy left 3 during push+pop, required 3"); else n_pass++;
        wait_drain(ok);
        n_chk++; if (got_q.size() != exp_q.size()) $display("FAIL simul_len: got %0d required %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_chk++; if (got_q[i] !== exp_q[i]) $display("FAIL simul_data[%0d]: got %h required %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
        n_chk++; if (flit_cnt !== exp_cnt) $display("FAIL simul_cnt: got %0d required %0d", flit_cnt, exp_cnt); else n_pass++;
        got_q.delete(); got_cyc.delete(); exp_q.delete();
    endtask

    task automatic test_cnt_wrap();
        int n0;
        int total;
        bit ok;
        total = (1 << CNT_W) + 1;
        rst = 1'b0;
        @(negedge clk);
        exp_q.delete(); got_q.delete(); got_cyc.delete();
        m_open = 1'b0; m_err = 1'b0; exp_cnt = '0;
        rst = 1'b1;
        bus.buffer_on = 1'b1;
        @(negedge clk);
        rec_en = 1'b0;
        n0 = n_launch;
        bus.flit_in = mk(T_HT);
        bus.flit_in_valid = 1'b1;
        repeat (total) @(negedge clk);
        idle();
        wait_drain(ok);
        n_chk++; if (n_launch - n0 != total) $display("FAIL wrap_launches: got %0d required %0d", n_launch - n0, total); else n_pass++;
        n_chk++; if (flit_cnt !== CNT_W'(1)) $display("FAIL wrap_cnt: got %0d required 1", flit_cnt); else n_pass++;
        n_chk++; if (proto_err !== 1'b0) $display("FAIL wrap_err: got %b required 0", proto_err); else n_pass++;
        rec_en = 1'b1;
    endtask

    initial begin
        bus.flit_in       = '0;
        bus.flit_in_valid = 1'b0;
        bus.buffer_on     = 1'b1;
        test_reset();
        test_stream();
        test_mid_reset();
        test_stop();
        test_framing();
        test_random();
        test_simul();
        test_cnt_wrap();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
